mor1kx_branch_prediction_ctrl: RTL

MOR1KX_BRANCH_PREDICTION_CTRL -- requirements
Module: mor1kx_branch_prediction_ctrl

---
 rtl/mor1kx_branch_prediction_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mor1kx_branch_prediction_ctrl.sv
// Branch prediction control: a table of 2-bit saturating counters indexed by PC,
// a small FIFO of unresolved predictions, and a registered mispredict pulse.
module mor1kx_branch_prediction_ctrl #(
  parameter int TABLE_AW   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_valid_i,
  input  logic        op_bf_i,
  input  logic        op_bnf_i,
  input  logic [31:0] pc_i,
  output logic        predicted_flag_o,
  output logic        stall_o,
  input  logic        resolve_valid_i,
  input  logic        flag_i,
  input  logic        flush_i,
  output logic        mispredict_o
);

  localparam int unsigned ENTRIES = 2 ** TABLE_AW;
  localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TABLE_AW-1:0] idx;
    logic                is_bf;
    logic                pred;
  } pend_t;

  logic [1:0]          ctr_q [ENTRIES];
  pend_t               fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;

  logic [TABLE_AW-1:0] idx;
  logic                taken;
  logic                full;
  logic                nonempty;
  logic                pop;
  logic                push;
  logic                mispredict_now;
  logic                actual_taken;
  pend_t               head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign idx      = pc_i[TABLE_AW+1:2];
  assign taken    = ctr_q[idx][1];
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign nonempty = (count != '0);
  assign pop      = resolve_valid_i & nonempty;
  assign head     = fifo_q[rd_ptr];

  // Prediction, stall and resolve decisions for the current cycle
  always_comb begin
    predicted_flag_o = 1'b0;
    if (op_bf_i)
      predicted_flag_o = taken;
    else if (op_bnf_i)
      predicted_flag_o = ~taken;
    stall_o        = full & ~pop;
    mispredict_now = pop & (flag_i != head.pred);
    actual_taken   = head.is_bf ? flag_i : ~flag_i;
    push           = decode_valid_i & (op_bf_i | op_bnf_i) & ~stall_o
                     & ~flush_i & ~mispredict_now;
  end

  // Counter table: trained by the head entry on every pop, saturating at 0 and 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (pop) begin
      if (actual_taken) begin
        if (ctr_q[head.idx] != 2'b11)
          ctr_q[head.idx] <= ctr_q[head.idx] + 2'b01;
      end else begin
        if (ctr_q[head.idx] != 2'b00)
          ctr_q[head.idx] <= ctr_q[head.idx] - 2'b01;
      end
    end
  end

  // Pending entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= '{idx: idx, is_bf: op_bf_i, pred: predicted_flag_o};
  end

  // FIFO pointers and occupancy; a mispredict or flush drops every pending entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i || mispredict_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // Registered one-cycle mispredict pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispredict_o <= 1'b0;
    else
      mispredict_o <= mispredict_now;
  end

endmodule
